// File: rtl/jtframe_i2s_tx_pkg.sv
// Shared I2S framing constants and the slot bit-select helper.
package jtframe_i2s_tx_pkg;

   localparam int SLOT  = 32;
   localparam int FRAME = 64;

   // Slot position s=1 addresses bit 31 (the MSB) and s=0 wraps to bit 0.
   // Bit 0 is always padding because W <= 24.
   function automatic logic slot_bit(input logic [SLOT-1:0] slot, input logic [4:0] s);
      return slot[5'd0 - s];
   endfunction

endpackage

// File: rtl/jtframe_peak_hold.sv
// Counter-based pulse stretcher: trig reloads HOLD, each tick counts down,
// and led stays high while the count is non-zero.
module jtframe_peak_hold #(
   parameter int CNTW = 12,
   parameter int HOLD = 2048
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic tick,
   output logic led
);

   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            led_q, led_d;

   always_comb begin
      cnt_d = cnt_q;
      if (trig)
         cnt_d = CNTW'(HOLD);
      else if (tick && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
      led_d = (cnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/jtframe_i2s_tx.sv
// Stereo I2S transmitter: a double-buffered sample input feeds two 32-bit slots
// that are shifted out MSB-first, with a stretched peak indicator.
module jtframe_i2s_tx
   import jtframe_i2s_tx_pkg::*;
#(
   parameter int W        = 16,
   parameter int HALFDIV  = 4,
   parameter int PEAKHOLD = 2048
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sample,
   input  logic [W-1:0] left,
   input  logic [W-1:0] right,
   input  logic         peak,
   output logic         ready,
   output logic         ovr,
   output logic         bclk,
   output logic         lrclk,
   output logic         sdata,
   output logic         peak_led
);

   localparam int DIVW = $clog2(HALFDIV);
   localparam int CNTW = $clog2(PEAKHOLD + 1);

   logic [DIVW-1:0] div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [5:0]      bc_q, bc_d;
   logic            started_q, started_d;
   logic            sdata_q, sdata_d;
   logic            full_q, full_d;
   logic            ovr_q, ovr_d;
   logic [W-1:0]    hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [W-1:0]    word_l_q, word_l_d, word_r_q, word_r_d;

   logic            div_tc, fall, load;
   logic [SLOT-1:0] slot_l, slot_r;

   always_comb begin
      div_tc = (div_q == DIVW'(HALFDIV - 1));
      fall   = div_tc & bclk_q;
      // The very first fall after reset opens frame 0 instead of advancing bc.
      load   = fall & (~started_q | (bc_q == 6'(FRAME - 1)));

      div_d     = div_tc ? '0 : div_q + 1'b1;
      bclk_d    = bclk_q ^ div_tc;
      started_d = started_q | fall;
      bc_d      = bc_q;
      if (fall && started_q)
         bc_d = bc_q + 6'd1;

      word_l_d = word_l_q;
      word_r_d = word_r_q;
      if (load && full_q) begin
         word_l_d = hold_l_q;
         word_r_d = hold_r_q;
      end

      slot_l  = {word_l_q, {(SLOT - W){1'b0}}};
      slot_r  = {word_r_q, {(SLOT - W){1'b0}}};
      sdata_d = sdata_q;
      if (fall)
         sdata_d = slot_bit(bc_d[5] ? slot_r : slot_l, bc_d[4:0]);

      // A strobe coinciding with a load refills the buffer the load just drained.
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      full_d   = full_q & ~load;
      ovr_d    = ovr_q;
      if (sample) begin
         hold_l_d = left;
         hold_r_d = right;
         full_d   = 1'b1;
         if (full_q && !load)
            ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         bclk_q    <= 1'b0;
         bc_q      <= '0;
         started_q <= 1'b0;
         sdata_q   <= 1'b0;
         full_q    <= 1'b0;
         ovr_q     <= 1'b0;
         hold_l_q  <= '0;
         hold_r_q  <= '0;
         word_l_q  <= '0;
         word_r_q  <= '0;
      end else begin
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         bc_q      <= bc_d;
         started_q <= started_d;
         sdata_q   <= sdata_d;
         full_q    <= full_d;
         ovr_q     <= ovr_d;
         hold_l_q  <= hold_l_d;
         hold_r_q  <= hold_r_d;
         word_l_q  <= word_l_d;
         word_r_q  <= word_r_d;
      end
   end

   jtframe_peak_hold #(
      .CNTW (CNTW),
      .HOLD (PEAKHOLD)
   ) u_peak (
      .clk  (clk),
      .rst  (rst),
      .trig (peak),
      .tick (load),
      .led  (peak_led)
   );

   assign ready = ~full_q;
   assign ovr   = ovr_q;
   assign bclk  = bclk_q;
   assign lrclk = bc_q[5];
   assign sdata = sdata_q;

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Bench for jtframe_i2s_tx: stimulus queues expected frames, a receiver
// deserialises sdata on bclk rises and compares each completed frame.
module tb_jtframe_i2s_tx;

   localparam int W        = 16;
   localparam int HALFDIV  = 4;
   localparam int PEAKHOLD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sample = 1'b0;
   logic         peak = 1'b0;
   logic [W-1:0] left = '0;
   logic [W-1:0] right = '0;
   logic         ready, ovr, bclk, lrclk, sdata, peak_led;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           id;
      logic [W-1:0] l;
      logic [W-1:0] r;
   } exp_t;
   exp_t sb[$];

   event frame_done;
   int   done_id = -1;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   jtframe_i2s_tx #(
      .W        (W),
      .HALFDIV  (HALFDIV),
      .PEAKHOLD (PEAKHOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sample   (sample),
      .left     (left),
      .right    (right),
      .peak     (peak),
      .ready    (ready),
      .ovr      (ovr),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .peak_led (peak_led)
   );

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slot bits as received in order s=0..31: a zero, the sample MSB-first, padding zeros.
   function automatic logic [31:0] slotv(input logic [W-1:0] w);
      return {1'b0, w, {(31 - W){1'b0}}};
   endfunction

   task automatic expect_frame(input int id, input logic [W-1:0] l, input logic [W-1:0] r);
      exp_t e;
      e.id = id;
      e.l  = l;
      e.r  = r;
      sb.push_back(e);
   endtask

   task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      @(negedge clk);
      left   = l;
      right  = r;
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
   endtask

   task automatic wait_frame(input int id);
      while (done_id < id) @(frame_done);
   endtask

   // Receiver / scoreboard monitor
   logic        mon_prev_lr = 1'b0;
   logic [31:0] mon_sh = '0;
   logic [31:0] mon_lval = '0;
   int          mon_cnt = 0;
   int          mon_lcnt = 0;
   int          mon_fid = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge bclk);
         #1;
         if (!mon_en) continue;
         if (lrclk !== mon_prev_lr) begin
            if (lrclk === 1'b1) begin
               mon_lval = mon_sh;
               mon_lcnt = mon_cnt;
            end else begin
               // Frame 0 also sees the rise that precedes the first fall.
               if (mon_fid > 0) begin
                  check32("left_slot_len", mon_lcnt, 32);
                  check32("right_slot_len", mon_cnt, 32);
               end
               while (sb.size() > 0 && sb[0].id < mon_fid) begin
                  e = sb.pop_front();
                  checks++;
                  errors++;
                  $display("FAIL frame_missing: frame %0d never seen, now at %0d", e.id, mon_fid);
               end
               if (sb.size() > 0 && sb[0].id == mon_fid) begin
                  e = sb.pop_front();
                  check32("left_word", mon_lval, slotv(e.l));
                  check32("right_word", mon_sh, slotv(e.r));
               end
               done_id = mon_fid;
               mon_fid++;
               ->frame_done;
            end
            mon_sh  = '0;
            mon_cnt = 0;
         end
         mon_sh = {mon_sh[30:0], sdata};
         mon_cnt++;
         mon_prev_lr = lrclk;
      end
   end

   initial begin : watchdog
      #400000;
      errors++;
      $display("FAIL watchdog: run did not complete, time %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stimulus
      int  f;
      time t0;
      logic exp_a [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      // 1: reset state and idle framing
      repeat (10) @(negedge clk);
      check1("rst_bclk", bclk, 1'b0);
      check1("rst_lrclk", lrclk, 1'b0);
      check1("rst_sdata", sdata, 1'b0);
      check1("rst_ready", ready, 1'b1);
      check1("rst_ovr", ovr, 1'b0);
      check1("rst_peak_led", peak_led, 1'b0);
      expect_frame(0, '0, '0);
      expect_frame(1, '0, '0);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(posedge bclk);
      t0 = $time;
      @(posedge bclk);
      check32("bclk_period_clk", 32'(($time - t0) / 10), 32'(2 * HALFDIV));

      // 2: single sample, ready handshake
      @(frame_done);
      f = done_id;
      send(16'h8001, 16'h7FFE);
      expect_frame(f + 2, 16'h8001, 16'h7FFE);
      check1("ready_after_strobe", ready, 1'b0);
      @(negedge lrclk);
      #1;
      check1("ready_after_load", ready, 1'b1);
      check1("ovr_single", ovr, 1'b0);

      // 4: underrun repeats the last words
      @(frame_done);
      f = done_id;
      send(16'h00FF, 16'hFF00);
      expect_frame(f + 2, 16'h00FF, 16'hFF00);
      expect_frame(f + 3, 16'h00FF, 16'hFF00);
      expect_frame(f + 4, 16'h00FF, 16'hFF00);
      wait_frame(f + 4);
      check1("ovr_underrun", ovr, 1'b0);

      // 5: strobe on the frame-load clock
      @(frame_done);
      f = done_id;
      send(16'hA5C3, 16'h3C5A);
      expect_frame(f + 2, 16'hA5C3, 16'h3C5A);
      @(posedge lrclk);
      repeat (32 * 2 * HALFDIV) @(negedge clk);
      check1("preload_lrclk", lrclk, 1'b1);
      check1("preload_bclk", bclk, 1'b1);
      left   = 16'h0F0F;
      right  = 16'hF0F0;
      sample = 1'b1;
      @(negedge clk);
      sample = 1'b0;
      check1("load_edge_lrclk", lrclk, 1'b0);
      check1("load_edge_ready", ready, 1'b0);
      check1("load_edge_ovr", ovr, 1'b0);
      expect_frame(f + 3, 16'h0F0F, 16'hF0F0);
      wait_frame(f + 3);
      check1("ovr_after_load_strobe", ovr, 1'b0);

      // 3: overrun, only the second sample survives
      @(frame_done);
      f = done_id;
      send(16'h1234, 16'h1234);
      repeat (20) @(negedge clk);
      check1("ovr_before_overrun", ovr, 1'b0);
      send(16'h5678, 16'h5678);
      check1("ovr_set", ovr, 1'b1);
      expect_frame(f + 2, 16'h5678, 16'h5678);
      wait_frame(f + 2);
      @(frame_done);
      f = done_id;
      send(16'h9ABC, 16'hDEF0);
      expect_frame(f + 2, 16'h9ABC, 16'hDEF0);
      wait_frame(f + 2);
      check1("ovr_sticky", ovr, 1'b1);

      // 6: peak stretching, single pulse then an extended one
      @(frame_done);
      @(negedge clk);
      peak = 1'b1;
      @(negedge clk);
      peak = 1'b0;
      check1("peak_led_set", peak_led, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge lrclk);
         #1;
         check1("peak_led_single", peak_led, exp_a[k]);
      end
      @(negedge clk);
      peak = 1'b1;
      @(negedge clk);
      peak = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge lrclk);
         #1;
         check1("peak_led_extend", peak_led, exp_b[k]);
         if (k == 1) begin
            @(negedge clk);
            peak = 1'b1;
            @(negedge clk);
            peak = 1'b0;
         end
      end

      // Reset mid-frame with bclk, lrclk, ovr and peak_led all high
      @(negedge clk);
      peak = 1'b1;
      @(negedge clk);
      peak = 1'b0;
      @(posedge lrclk);
      @(posedge bclk);
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check1("midrst_bclk", bclk, 1'b0);
      check1("midrst_lrclk", lrclk, 1'b0);
      check1("midrst_sdata", sdata, 1'b0);
      check1("midrst_ready", ready, 1'b1);
      check1("midrst_ovr", ovr, 1'b0);
      check1("midrst_peak_led", peak_led, 1'b0);

      check32("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
